// File: rtl/bht_predictor.sv
// Branch history table: 2-bit saturating counters with a registered update stage.
// Optional macro BHT_UPDATE_FWD_EN forwards the pending update onto the lookup path.
module bht_predictor #(
    parameter int unsigned VLEN       = 64,
    parameter int unsigned NR_ENTRIES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    output logic            bht_valid_o,
    output logic            bht_taken_o,
    output logic [1:0]      bht_counter_o,
    input  logic            res_valid_i,
    input  logic [VLEN-1:0] res_pc_i,
    input  logic            res_is_taken_i,
    input  logic            res_is_branch_i
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    logic             valid_q [NR_ENTRIES];
    logic [1:0]       cnt_q   [NR_ENTRIES];

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic [1:0]       upd_cnt_q, upd_cnt_d;

    logic [IDX_W-1:0] res_idx, lk_idx;
    logic             cur_valid, lk_valid;
    logic [1:0]       cur_cnt, new_cnt, lk_cnt;
    logic             unused_pc_bits;

    assign res_idx = res_pc_i[IDX_W:1];
    assign lk_idx  = vpc_i[IDX_W:1];
    assign unused_pc_bits = ^{res_pc_i[VLEN-1:IDX_W+1], res_pc_i[0],
                              vpc_i[VLEN-1:IDX_W+1], vpc_i[0]};

    // The pending write is not yet in the array, so it overrides the read for accumulation.
    always_comb begin
        cur_valid = valid_q[res_idx];
        cur_cnt   = cnt_q[res_idx];
        if (upd_valid_q && (upd_idx_q == res_idx)) begin
            cur_valid = 1'b1;
            cur_cnt   = upd_cnt_q;
        end

        if (!cur_valid) begin
            new_cnt = res_is_taken_i ? 2'b10 : 2'b01;
        end else if (res_is_taken_i) begin
            new_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
        end else begin
            new_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
        end

        upd_valid_d = res_valid_i & res_is_branch_i & ~debug_mode_i & ~flush_i;
        upd_idx_d   = res_idx;
        upd_cnt_d   = new_cnt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_cnt_q   <= 2'b00;
        end else begin
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_cnt_q   <= upd_cnt_d;
        end
    end

    // Flush takes priority over the pending write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b00;
            end
        end else begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                if (flush_i) begin
                    valid_q[i] <= 1'b0;
                    cnt_q[i]   <= 2'b00;
                end else if (upd_valid_q && (upd_idx_q == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    cnt_q[i]   <= upd_cnt_q;
                end
            end
        end
    end

    always_comb begin
        lk_valid = valid_q[lk_idx];
        lk_cnt   = cnt_q[lk_idx];
`ifdef BHT_UPDATE_FWD_EN
        if (upd_valid_q && (upd_idx_q == lk_idx)) begin
            lk_valid = 1'b1;
            lk_cnt   = upd_cnt_q;
        end
`endif
        bht_valid_o   = lk_valid;
        bht_counter_o = lk_valid ? lk_cnt : 2'b00;
        bht_taken_o   = lk_valid & lk_cnt[1];
    end
endmodule

// File: tb/tb_bht_predictor.sv
// Directed plus random bench for bht_predictor against an outcome-level table model.
module tb_bht_predictor;
    localparam int NR = 1024;

    logic        clk, rst_n, flush, dbg;
    logic [63:0] vpc, res_pc;
    logic        res_valid, res_taken, res_branch;
    logic        bht_valid, bht_taken;
    logic [1:0]  bht_counter;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: table holds the outcome of every accepted resolution immediately;
    // "last" remembers the pre-update value of the most recent accepted entry,
    // which is what a non-forwarding lookup still sees one cycle later.
    bit m_v [NR];
    int m_c [NR];
    bit last_v;
    int last_i;
    bit last_valid;
    int last_cnt;

    bht_predictor dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(dbg),
        .vpc_i(vpc), .bht_valid_o(bht_valid), .bht_taken_o(bht_taken),
        .bht_counter_o(bht_counter), .res_valid_i(res_valid), .res_pc_i(res_pc),
        .res_is_taken_i(res_taken), .res_is_branch_i(res_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [63:0] pc);
        return int'(pc[10:1]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_v[i] = 1'b0;
            m_c[i] = 0;
        end
        last_v = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int  i;
        bit  v;
        int  c;
        i = idx_of(vpc);
        v = m_v[i];
        c = m_c[i];
`ifndef BHT_UPDATE_FWD_EN
        if (last_v && last_i == i) begin
            v = last_valid;
            c = last_cnt;
        end
`endif
        if (!v) c = 0;
        chk({tag, "_valid"}, {1'b0, bht_valid}, {1'b0, v});
        chk({tag, "_cnt"}, bht_counter, 2'(c));
        chk({tag, "_taken"}, {1'b0, bht_taken}, {1'b0, v && c >= 2});
    endtask

    task automatic cyc(input logic fl, input logic db, input logic [63:0] lpc,
                       input logic rv, input logic [63:0] rpc, input logic rt, input logic rb);
        int i;
        @(negedge clk);
        flush = fl; dbg = db; vpc = lpc;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_branch = rb;
        #1 check_model("model");
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else if (rv && rb && !db) begin
            i = idx_of(rpc);
            last_v = 1'b1; last_i = i; last_valid = m_v[i]; last_cnt = m_c[i];
            if (!m_v[i])  m_c[i] = rt ? 2 : 1;
            else if (rt)  m_c[i] = (m_c[i] + 1 > 3) ? 3 : m_c[i] + 1;
            else          m_c[i] = (m_c[i] - 1 < 0) ? 0 : m_c[i] - 1;
            m_v[i] = 1'b1;
        end else begin
            last_v = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, vpc, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [63:0] pc, input logic t);
        cyc(1'b0, 1'b0, pc, 1'b1, pc, t, 1'b1);
    endtask

    // Constant-expectation lookup between the posedge and the following negedge.
    task automatic look(input string tag, input logic [63:0] pc, input logic ev, input logic [1:0] ec);
        #1 vpc = pc;
        #1;
        chk({tag, "_valid"}, {1'b0, bht_valid}, {1'b0, ev});
        chk({tag, "_cnt"}, bht_counter, ec);
        chk({tag, "_taken"}, {1'b0, bht_taken}, {1'b0, ev & ec[1]});
    endtask

    localparam bit FWD =
`ifdef BHT_UPDATE_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        rst_n = 1'b0; flush = 1'b0; dbg = 1'b0; vpc = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_branch = 1'b0;
        model_clear();

        for (int pc = 0; pc < 'h800; pc += 2) begin
            vpc = 64'(pc);
            #1;
            chk("reset_valid", {1'b0, bht_valid}, 2'd0);
            chk("reset_cnt", bht_counter, 2'd0);
            chk("reset_taken", {1'b0, bht_taken}, 2'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        upd(64'h8000_0010, 1'b1);
        look("first_n1", 64'h8000_0010, FWD, FWD ? 2'b10 : 2'b00);
        idle(1);
        look("first_n2", 64'h8000_0010, 1'b1, 2'b10);
        look("first_alias", 64'h8000_0810, 1'b1, 2'b10);

        for (int k = 0; k < 4; k++) upd(64'h100, 1'b1);
        idle(2);
        look("sat_up", 64'h100, 1'b1, 2'b11);
        for (int k = 0; k < 5; k++) upd(64'h100, 1'b0);
        idle(2);
        look("sat_down", 64'h100, 1'b1, 2'b00);

        cyc(1'b0, 1'b0, 64'h200, 1'b1, 64'h200, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 1'b1);
        idle(3);
        look("filter", 64'h200, 1'b0, 2'b00);

        upd(64'h300, 1'b1);
        cyc(1'b1, 1'b0, 64'h300, 1'b0, 64'h0, 1'b0, 1'b0);
        look("flush_race", 64'h300, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 64'h300, 1'b1, 64'h300, 1'b1, 1'b1);
        idle(2);
        look("flush_same", 64'h300, 1'b0, 2'b00);
        look("flush_all", 64'h100, 1'b0, 2'b00);

        upd(64'h400, 1'b1);
        look("fwd_n1", 64'h400, FWD, FWD ? 2'b10 : 2'b00);
        idle(1);
        look("fwd_n2", 64'h400, 1'b1, 2'b10);

        upd(64'h500, 1'b1);
        upd(64'h500, 1'b1);
        idle(2);
        look("b2b_acc", 64'h500, 1'b1, 2'b11);

        #1 vpc = 64'h500;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_valid", {1'b0, bht_valid}, 2'd0);
        chk("midrst_cnt", bht_counter, 2'd0);
        rst_n = 1'b1;
        idle(1);

        for (int k = 0; k < 400; k++) begin
            logic [63:0] lp, rp;
            lp = 64'($urandom_range(0, 7) * 2) | (64'($urandom_range(0, 3)) << 11);
            rp = 64'($urandom_range(0, 7) * 2) | (64'($urandom_range(0, 3)) << 11) | 64'($urandom_range(0, 1));
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, lp,
                $urandom_range(0, 3) != 0, rp, 1'($urandom), $urandom_range(0, 5) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Branch history table (BHT) that consumes branch resolutions from the branch unit.
- Supplies a direction prediction to the frontend for the current fetch PC.
- Holds one valid bit and one 2-bit saturating counter per entry, updated through a one-cycle registered update stage.
- Sits directly downstream of the branch unit's resolution output and upstream of PC generation.

Parameters:
- VLEN, 64, virtual address width.
- NR_ENTRIES, 1024, number of BHT entries; must be a power of two and at least 2.
- IDX_W, $clog2(NR_ENTRIES), index width; derived, not overridable.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous clear of the entire table.
- debug_mode_i  input  1  when 1, resolutions are ignored and no update is captured.
- vpc_i  input  VLEN  fetch PC to predict for.
- bht_valid_o  output  1  the entry indexed by vpc_i holds a valid counter.
- bht_taken_o  output  1  predicted direction, equal to counter[1]; 0 when not valid.
- bht_counter_o  output  2  raw counter of the looked-up entry; 0 when not valid.
- res_valid_i  input  1  branch resolution valid.
- res_pc_i  input  VLEN  PC of the resolved instruction.
- res_is_taken_i  input  1  actual outcome of the branch.
- res_is_branch_i  input  1  the resolved control-flow type is a conditional branch.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
- Indexing: idx(pc) = pc[IDX_W:1]. Bit 0 is ignored, so compressed instructions are covered. Upper bits are not tagged, so aliasing is accepted.
- Storage: NR_ENTRIES × {valid, cnt[1:0]} held in flops.
- Reset: all valid=0, all cnt=0, update register empty. Outputs are therefore 0 immediately, asynchronously.
- Lookup is combinational from the array and the forwarding path (below); zero latency.
  - bht_valid_o = entry.valid.
  - bht_counter_o = valid ? cnt : 0.
  - bht_taken_o = valid ? cnt[1] : 0.
- Update capture (cycle N): when res_valid_i & res_is_branch_i & !debug_mode_i & !flush_i, the update register stores {idx, new_valid=1, new_cnt}.
  - Non-branch resolutions (jumps, returns) are never captured.
- new_cnt is computed in cycle N from the current array value of the entry, taking a pending write into account (read-after-write safe):
  - Entry invalid: new_cnt = taken ? 2'b10 : 2'b01.
  - Entry valid, taken: cnt==3 ? 3 : cnt+1.
  - Entry valid, not taken: cnt==0 ? 0 : cnt-1.
- Array write (cycle N+1): the update register writes the entry.
- Back-to-back updates to the same index in consecutive cycles must accumulate. For example, two taken updates from an invalid entry must end at 2'b11, not 2'b10.
- Update register capacity: one entry, overwritten every cycle. It never stalls, and there is no backpressure toward the branch unit.
- Flush: flush_i=1 in cycle N clears every valid bit and every cnt at the edge ending cycle N.
  - Discards any update pending in the register; flush wins over the pending write.
  - Resolutions presented in a flush cycle are dropped.
- Reset mid-operation: an asserted rst_ni immediately clears the array and the update register, regardless of clock.

Optional Feature:
- Macro: BHT_UPDATE_FWD_EN.
- Defined: when the update register is pending and its idx equals idx(vpc_i), lookup outputs use the pending {valid, cnt} instead of the array value. The prediction sees the update one cycle earlier (cycle N+1 rather than N+2).
- Undefined: lookup reads the array only. In cycle N+1 a matching lookup returns the pre-update value.
- Internal read-after-write accumulation for new_cnt is required in both builds.

Test Plan:
- Reset: hold rst_ni=0 and sweep vpc_i across 0x0–0x7FE → bht_valid_o=0, bht_taken_o=0, bht_counter_o=0 for all.
- First update: res pc=0x8000_0010, taken=1, branch=1 → from cycle N+2, a lookup at vpc 0x8000_0010 returns valid=1, counter=2'b10, taken=1. A lookup at alias 0x8000_0810 returns the same.
- Saturation: four consecutive taken updates at 0x100 → counter 10, 11, 11, 11. Then five not-taken updates → 10, 01, 00, 00, 00; taken=0 once the counter reaches 01.
- Filtering: res_valid_i=1 with res_is_branch_i=0, or with debug_mode_i=1, at 0x200 → the entry stays valid=0 indefinitely.
- Flush race: update at 0x300 in cycle N, flush_i=1 in cycle N+1 → entry at 0x300 reads valid=0 from cycle N+2. A simultaneous flush and resolution also leaves valid=0.
- Forwarding: update at 0x400 in cycle N with lookup vpc 0x400 in cycle N+1 → valid=1, counter=10 with BHT_UPDATE_FWD_EN; valid=0 without it. Both builds read 10 in cycle N+2.
